// File: rtl/alu_share_ctrl.sv
// ----------------------------------------------------------------------------
// alu_share_ctrl
//
// Purpose:
//   Sequences one shared 32-bit combinational ALU that lives outside this
//   block. Two requesters compete for it:
//     - requester 0 is the pipeline EX stage
//     - requester 1 is an auxiliary unit, such as an iterative mul/div
//       sequencer
//   A round-robin arbiter picks the winner. The winner's operands are latched
//   into registers that drive the ALU, and the ALU result and zero flag are
//   captured one cycle later. That captured result goes back to the granted
//   requester together with a one-cycle done pulse.
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   req0/a0/b0/aluc0      requester 0: level request, operands, op code
//   ack0, done0           requester 0: operands-accepted pulse, result pulse
//   req1/a1/b1/aluc1      requester 1: same meaning as requester 0
//   ack1, done1           requester 1: same meaning as requester 0
//   alu_a/alu_b/alu_aluc  registered operands and op code to the shared ALU
//   alu_r, alu_z          result and zero flag back from the shared ALU
//   r_out, z_out          captured result and flag, held until next completion
//   busy                  high while an operation occupies the ALU (EXEC)
//
// Timing:
//   A request is sampled in cycle T:
//     - ack and busy are high in T+1, the EXEC cycle
//     - done, r_out and z_out are valid in T+2
//   A request still high in T+2 is granted again, so the block sustains one
//   operation every two cycles.
//
// Registered outputs:
//   Every output comes from a flop. No input reaches an output
//   combinationally.
// ----------------------------------------------------------------------------
module alu_share_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,

    // Requester 0 (pipeline EX)
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [OPW-1:0]   aluc0,
    output logic             ack0,
    output logic             done0,

    // Requester 1 (auxiliary unit)
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [OPW-1:0]   aluc1,
    output logic             ack1,
    output logic             done1,

    // Shared ALU interface
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_aluc,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_z,

    // Captured result
    output logic [WIDTH-1:0] r_out,
    output logic             z_out,
    output logic             busy
);

    typedef enum logic {
        StIdle,
        StExec
    } state_e;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e           state_q,    state_d;
    logic             prio_q,     prio_d;     // requester favoured on a tie
    logic             g_q,        g_d;        // requester owning the current op

    logic [WIDTH-1:0] alu_a_q,    alu_a_d;
    logic [WIDTH-1:0] alu_b_q,    alu_b_d;
    logic [OPW-1:0]   alu_aluc_q, alu_aluc_d;

    logic [WIDTH-1:0] r_q,        r_d;
    logic             z_q,        z_d;

    logic             ack0_q,     ack0_d;
    logic             ack1_q,     ack1_d;
    logic             done0_q,    done0_d;
    logic             done1_q,    done1_d;
    logic             busy_q,     busy_d;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    logic             grant_valid;
    logic             grant_sel;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [OPW-1:0]   sel_aluc;

    always_comb begin
        grant_valid = req0 | req1;

        // A lone requester wins outright; a tie goes to prio_q.
        if (req0 && req1) begin
            grant_sel = prio_q;
        end else begin
            grant_sel = req1;
        end

        if (grant_sel) begin
            sel_a    = a1;
            sel_b    = b1;
            sel_aluc = aluc1;
        end else begin
            sel_a    = a0;
            sel_b    = b0;
            sel_aluc = aluc0;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // By default everything holds, and the pulse outputs drop back to 0.
        state_d    = state_q;
        prio_d     = prio_q;
        g_d        = g_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_aluc_d = alu_aluc_q;
        r_d        = r_q;
        z_d        = z_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        busy_d     = 1'b0;

        case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    alu_a_d    = sel_a;
                    alu_b_d    = sel_b;
                    alu_aluc_d = sel_aluc;
                    g_d        = grant_sel;
                    ack0_d     = ~grant_sel;
                    ack1_d     = grant_sel;
                    prio_d     = ~grant_sel;
                    busy_d     = 1'b1;
                    state_d    = StExec;
                end
            end

            StExec: begin
                // The ALU has had a full cycle on stable registered inputs.
                // Request inputs are ignored here.
                r_d     = alu_r;
                z_d     = alu_z;
                done0_d = ~g_q;
                done1_d = g_q;
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // Resetting mid-operation discards the operation without a done.
            state_q    <= StIdle;
            prio_q     <= 1'b0;
            g_q        <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_aluc_q <= '0;
            r_q        <= '0;
            z_q        <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            g_q        <= g_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_aluc_q <= alu_aluc_d;
            r_q        <= r_d;
            z_q        <= z_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            busy_q     <= busy_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_aluc = alu_aluc_q;
    assign r_out    = r_q;
    assign z_out    = z_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// ----------------------------------------------------------------------------
// tb_alu_share_ctrl
//
// Directed bench for alu_share_ctrl. A small combinational ALU stands in for
// the external shared ALU, using these op codes:
//   0000  ADD
//   0100  SUB
//   0101  OR
//   0110  LUI, which returns b[15:0] << 16
// ----------------------------------------------------------------------------
module tb_alu_share_ctrl;

    logic        clk;
    logic        rst;
    logic        req0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [3:0]  aluc0;
    logic        ack0;
    logic        done0;
    logic        req1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [3:0]  aluc1;
    logic        ack1;
    logic        done1;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_aluc;
    logic [31:0] alu_r;
    logic        alu_z;
    logic [31:0] r_out;
    logic        z_out;
    logic        busy;

    int total;
    int bad;

    alu_share_ctrl #(
        .WIDTH (32),
        .OPW   (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .a0       (a0),
        .b0       (b0),
        .aluc0    (aluc0),
        .ack0     (ack0),
        .done0    (done0),
        .req1     (req1),
        .a1       (a1),
        .b1       (b1),
        .aluc1    (aluc1),
        .ack1     (ack1),
        .done1    (done1),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_aluc (alu_aluc),
        .alu_r    (alu_r),
        .alu_z    (alu_z),
        .r_out    (r_out),
        .z_out    (z_out),
        .busy     (busy)
    );

    // Stand-in for the external shared ALU.
    always_comb begin
        case (alu_aluc)
            4'b0000: alu_r = alu_a + alu_b;
            4'b0100: alu_r = alu_a - alu_b;
            4'b0101: alu_r = alu_a | alu_b;
            4'b0110: alu_r = {alu_b[15:0], 16'h0000};
            default: alu_r = 32'h0;
        endcase
        alu_z = (alu_r == 32'h0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Packs the pulse outputs as {ack0, ack1, done0, done1, busy}.
    function automatic logic [31:0] pulses();
        return {27'h0, ack0, ack1, done0, done1, busy};
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        req0  = 1'b0;
        a0    = '0;
        b0    = '0;
        aluc0 = '0;
        req1  = 1'b0;
        a1    = '0;
        b1    = '0;
        aluc1 = '0;

        // ---- Reset state ----
        tick();
        tick();
        chk("rst_pulses",   pulses(),        32'h0);
        chk("rst_alu_a",    alu_a,           32'h0);
        chk("rst_alu_b",    alu_b,           32'h0);
        chk("rst_alu_aluc", 32'(alu_aluc),   32'h0);
        chk("rst_r_out",    r_out,           32'h0);
        chk("rst_z_out",    32'(z_out),      32'h0);
        rst = 1'b0;

        // ---- Requester 0 alone: ADD 5 + 3 ----
        req0  = 1'b1;
        a0    = 32'd5;
        b0    = 32'd3;
        aluc0 = 4'b0000;
        tick();
        chk("t1_ack_pulses", pulses(), 32'b10001);   // ack0 and busy
        chk("t1_alu_a",      alu_a,    32'd5);
        chk("t1_alu_b",      alu_b,    32'd3);
        req0 = 1'b0;
        tick();
        chk("t1_done_pulses", pulses(),   32'b00100); // done0 only
        chk("t1_r_out",       r_out,      32'd8);
        chk("t1_z_out",       32'(z_out), 32'h0);

        // ---- Requester 1 alone: SUB 7 - 7 ----
        req1  = 1'b1;
        a1    = 32'd7;
        b1    = 32'd7;
        aluc1 = 4'b0100;
        tick();
        chk("t2_ack_pulses",  pulses(),      32'b01001); // ack1 and busy
        chk("t2_alu_aluc",    32'(alu_aluc), 32'h4);
        req1 = 1'b0;
        tick();
        chk("t2_done_pulses", pulses(),   32'b00010); // done1 only
        chk("t2_r_out",       r_out,      32'h0);
        chk("t2_z_out",       32'(z_out), 32'h1);

        // ---- Both requests held from reset: ADD 1+1 vs LUI 0x1234 ----
        rst   = 1'b1;
        req0  = 1'b1;
        a0    = 32'd1;
        b0    = 32'd1;
        aluc0 = 4'b0000;
        req1  = 1'b1;
        a1    = 32'd0;
        b1    = 32'h1234;
        aluc1 = 4'b0110;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("rr%0d_ack0", i), pulses(), 32'b10001);
            tick();
            chk($sformatf("rr%0d_done0", i), pulses(), 32'b00100);
            chk($sformatf("rr%0d_r0", i),    r_out,    32'h00000002);
            tick();
            // Second grant lands while done0 was high in the prior cycle.
            chk($sformatf("rr%0d_ack1", i), pulses(), 32'b01001);
            tick();
            chk($sformatf("rr%0d_done1", i), pulses(), 32'b00010);
            chk($sformatf("rr%0d_r1", i),    r_out,    32'h12340000);
        end

        // ---- Reset during EXEC of ADD 0xFFFFFFFF + 1 ----
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        req0  = 1'b1;
        a0    = 32'hFFFF_FFFF;
        b0    = 32'd1;
        aluc0 = 4'b0000;
        tick();
        chk("ra_ack0", pulses(), 32'b10001);
        // Grant 0 moved prio to 1; reset must return it to 0.
        rst  = 1'b1;
        req0 = 1'b0;
        tick();
        chk("ra_no_done",  pulses(),      32'h0);
        chk("ra_alu_aluc", 32'(alu_aluc), 32'h0);
        chk("ra_alu_a",    alu_a,         32'h0);
        chk("ra_r_out",    r_out,         32'h0);
        rst   = 1'b0;
        req0  = 1'b1;
        a0    = 32'd2;
        b0    = 32'd3;
        aluc0 = 4'b0000;
        req1  = 1'b1;
        a1    = 32'd0;
        b1    = 32'h5555;
        aluc1 = 4'b0110;
        tick();
        chk("ra_prio_ack0", pulses(), 32'b10001);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        chk("ra_done0", pulses(), 32'b00100);
        chk("ra_r_out", r_out,    32'd5);

        // ---- Operands latched: a0 changes from 10 to 99 in the ack cycle ----
        req0  = 1'b1;
        a0    = 32'd10;
        b0    = 32'd6;
        aluc0 = 4'b0101;
        tick();
        chk("lat_ack0", pulses(), 32'b10001);
        a0   = 32'd99;
        req0 = 1'b0;
        tick();
        chk("lat_done0", pulses(), 32'b00100);
        chk("lat_r_out", r_out,    32'h0000000E);

        // ---- Idle stability after a result of 0x1234 ----
        req1  = 1'b1;
        a1    = 32'h1000;
        b1    = 32'h0234;
        aluc1 = 4'b0000;
        tick();
        req1 = 1'b0;
        a1   = 32'hDEAD;
        b1   = 32'hBEEF;
        tick();
        chk("idle_done1", pulses(), 32'b00010);
        chk("idle_r0",    r_out,    32'h1234);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("idle%0d_pulses", i), pulses(),      32'h0);
            chk($sformatf("idle%0d_r_out", i),  r_out,         32'h1234);
            chk($sformatf("idle%0d_alu_a", i),  alu_a,         32'h1000);
            chk($sformatf("idle%0d_alu_b", i),  alu_b,         32'h0234);
            chk($sformatf("idle%0d_aluc", i),   32'(alu_aluc), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
